// File: rtl/umq_pkg.sv
// Shared definitions for the unexpected-message-queue scheduler.
//   - default widths and depth/timeout limits for umq_scheduler
//   - occupancy and wait-counter widths
//   - FSM state encoding
package umq_pkg;

    localparam int unsigned PKT_WIDTH_DEF = 128;
    localparam int unsigned REQ_WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF     = 1023;
    localparam int unsigned TIMEOUT_DEF   = 1100;

    // Occupancy is exported as a 10-bit count; the wait counter is sized
    // generously so TIMEOUT can be raised without touching the RTL.
    localparam int unsigned OCC_W = 10;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INS        = 3'd1,
        INS_SETTLE = 3'd2,
        FIND       = 3'd3,
        WAIT       = 3'd4,
        RESP       = 3'd5
    } state_t;

endpackage

// File: rtl/umq_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req[1:0] : request lines (bit 0 = message stream, bit 1 = request stream)
//   update   : a granted transfer completed this cycle; advance the pointer
//   grant    : one-hot grant (combinational)
// After reset bit 0 wins a tie. A lone requester is always granted.
module umq_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 1: bit 1 has priority on the next tie, 0: bit 0 has priority
    logic prio_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Priority flips to whichever side was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            prio_q <= grant[0];
        end
    end

endmodule

// File: rtl/umq_scheduler.sv
// Scheduler sitting in front of an unexpected-message list. Network messages
// are inserted into the list; receive posts search it. Only one list
// operation is ever outstanding.
//   clk, rst                         : clock, async active-high reset
//   msg_valid/msg_data/msg_ready     : network insert stream
//   req_valid/req_data/req_ready     : receive-post find stream
//   ll_insert/ll_find                : single-cycle list command strobes
//   ll_message/ll_request            : list command operands (held stable)
//   ll_found/ll_not_found            : list search result pulses
//   ll_q_full                        : list reports it cannot take inserts
//   ll_unexpected_message            : message returned by a successful find
//   rsp_*                            : find response, valid/ready handshake
//   occupancy                        : entries believed to be in the list
//   busy                             : scheduler not idle
module umq_scheduler
    import umq_pkg::*;
#(
    parameter int unsigned PKT_WIDTH = PKT_WIDTH_DEF,
    parameter int unsigned REQ_WIDTH = REQ_WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 msg_valid,
    input  logic [PKT_WIDTH-1:0] msg_data,
    output logic                 msg_ready,
    input  logic                 req_valid,
    input  logic [REQ_WIDTH-1:0] req_data,
    output logic                 req_ready,
    output logic                 ll_insert,
    output logic                 ll_find,
    output logic [PKT_WIDTH-1:0] ll_message,
    output logic [31:0]          ll_request,
    input  logic                 ll_found,
    input  logic                 ll_not_found,
    input  logic                 ll_q_full,
    input  logic [PKT_WIDTH-1:0] ll_unexpected_message,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_hit,
    output logic                 rsp_timeout,
    output logic [PKT_WIDTH-1:0] rsp_message,
    output logic [REQ_WIDTH-1:0] rsp_request,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [PKT_WIDTH-1:0] msg_q, msg_d;
    logic [REQ_WIDTH-1:0] req_q, req_d;
    logic                 hit_q, hit_d;
    logic                 tout_q, tout_d;
    logic [PKT_WIDTH-1:0] rmsg_q, rmsg_d;

    logic       full;
    logic [1:0] arb_req;
    logic [1:0] arb_grant;
    logic       arb_update;

    assign full    = ll_q_full || (occ_q == OCC_W'(DEPTH));
    assign arb_req = {req_valid, msg_valid && !full};

    umq_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .update (arb_update),
        .grant  (arb_grant)
    );

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        tmo_d      = tmo_q;
        msg_d      = msg_q;
        req_d      = req_q;
        hit_d      = hit_q;
        tout_d     = tout_q;
        rmsg_d     = rmsg_q;
        msg_ready  = 1'b0;
        req_ready  = 1'b0;
        ll_insert  = 1'b0;
        ll_find    = 1'b0;
        arb_update = 1'b0;

        case (state_q)
            IDLE: begin
                // Readies are masked by rst so they drop the instant reset rises.
                msg_ready = arb_grant[0] && !rst;
                req_ready = arb_grant[1] && !rst;
                if (msg_valid && msg_ready) begin
                    msg_d      = msg_data;
                    arb_update = 1'b1;
                    state_d    = INS;
                end else if (req_valid && req_ready) begin
                    req_d      = req_data;
                    arb_update = 1'b1;
                    if (occ_q == '0) begin
                        // Nothing can match an empty list: answer a miss directly.
                        hit_d   = 1'b0;
                        tout_d  = 1'b0;
                        rmsg_d  = '0;
                        state_d = RESP;
                    end else begin
                        state_d = FIND;
                    end
                end
            end
            INS: begin
                ll_insert = 1'b1;
                if (occ_q != OCC_W'(DEPTH)) begin
                    occ_d = occ_q + 1'b1;
                end
                state_d = INS_SETTLE;
            end
            INS_SETTLE: begin
                state_d = IDLE;
            end
            FIND: begin
                ll_find = 1'b1;
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A simultaneous found/not_found is resolved as found.
                if (ll_found) begin
                    hit_d  = 1'b1;
                    tout_d = 1'b0;
                    rmsg_d = ll_unexpected_message;
                    if (occ_q != '0) begin
                        occ_d = occ_q - 1'b1;
                    end
                    state_d = RESP;
                end else if (ll_not_found) begin
                    hit_d   = 1'b0;
                    tout_d  = 1'b0;
                    rmsg_d  = '0;
                    state_d = RESP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    hit_d   = 1'b0;
                    tout_d  = 1'b1;
                    rmsg_d  = '0;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            tmo_q   <= '0;
            msg_q   <= '0;
            req_q   <= '0;
            hit_q   <= 1'b0;
            tout_q  <= 1'b0;
            rmsg_q  <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            tmo_q   <= tmo_d;
            msg_q   <= msg_d;
            req_q   <= req_d;
            hit_q   <= hit_d;
            tout_q  <= tout_d;
            rmsg_q  <= rmsg_d;
        end
    end

    assign ll_message  = msg_q;
    assign ll_request  = 32'(req_q);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_hit     = hit_q;
    assign rsp_timeout = tout_q;
    assign rsp_message = rmsg_q;
    assign rsp_request = req_q;
    assign occupancy   = occ_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_umq_scheduler.sv
// Self-checking bench for umq_scheduler. The bench plays the role of the
// list, keeps a reference list of messages at transaction level, pushes the
// expected response for every accepted receive post, and a monitor pops and
// compares each response as it is handed over.
module tb_umq_scheduler;

    localparam int PW  = 128;
    localparam int RW  = 32;
    localparam int DEP = 6;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          msg_valid, msg_ready, req_valid, req_ready;
    logic [PW-1:0] msg_data;
    logic [RW-1:0] req_data;
    logic          ll_insert, ll_find, ll_found, ll_not_found, ll_q_full;
    logic [PW-1:0] ll_message, ll_unexpected_message;
    logic [31:0]   ll_request;
    logic          rsp_valid, rsp_ready, rsp_hit, rsp_timeout;
    logic [PW-1:0] rsp_message;
    logic [RW-1:0] rsp_request;
    logic [9:0]    occupancy;
    logic          busy;

    umq_scheduler #(.PKT_WIDTH(PW), .REQ_WIDTH(RW), .DEPTH(DEP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ll_insert(ll_insert), .ll_find(ll_find), .ll_message(ll_message), .ll_request(ll_request),
        .ll_found(ll_found), .ll_not_found(ll_not_found), .ll_q_full(ll_q_full),
        .ll_unexpected_message(ll_unexpected_message),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_timeout(rsp_timeout),
        .rsp_message(rsp_message), .rsp_request(rsp_request),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic          tout;
        logic [PW-1:0] msg;
        logic [RW-1:0] req;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [PW-1:0] ref_list[$];   // messages the list should hold, oldest first
    int unsigned   checks = 0, passes = 0;
    int unsigned   cyc = 0;
    int            ready_mode = 0; // 0 random, 1 hold low, 2 hold high
    bit            list_silent = 0;
    int unsigned   n_find = 0, n_insert = 0, n_msg_hs = 0, n_req_hs = 0;
    int            grant_log[$];
    int unsigned   find_cyc = 0;
    logic [PW-1:0] last_msg = '0;
    logic [31:0]   last_req = '0;
    rsp_t          e_new, e_got;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [PW-1:0] make_msg(input logic [23:0] key);
        logic [PW-1:0] m;
        m = {$urandom, $urandom, $urandom, $urandom};
        m[111:88] = key;
        return m;
    endfunction

    // ---------------- list emulator ----------------
    logic [PW-1:0] lst[$];
    int            pend = 0;
    logic [31:0]   preq = '0;

    always @(negedge clk) begin
        ll_found = 1'b0;
        ll_not_found = 1'b0;
        ll_unexpected_message = '0;
        if (rst) begin
            lst.delete();
            pend = 0;
        end else begin
            if (ll_insert) lst.push_back(ll_message);
            if (ll_find && !list_silent) begin
                pend = $urandom_range(1, 4);
                preq = ll_request;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ll_not_found = 1'b1;
                    for (int i = 0; i < lst.size(); i++) begin
                        if (lst[i][111:88] == preq[23:0]) begin
                            ll_found = 1'b1;
                            ll_not_found = ($urandom_range(0, 3) == 0);
                            ll_unexpected_message = lst[i];
                            lst.delete(i);
                            break;
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ref_list.delete();
        end else begin
            if (ll_insert || ll_find) check("one_list_op", PW'(ll_insert & ll_find), '0);
            if (ll_insert) begin
                n_insert++;
                check("ll_message", ll_message, last_msg);
            end
            if (ll_find) begin
                n_find++;
                find_cyc = cyc;
                check("ll_request", PW'(ll_request), PW'(last_req));
            end
            if (msg_valid && msg_ready) begin
                check("msg_not_full", PW'(ref_list.size() < DEP), PW'(1));
                ref_list.push_back(msg_data);
                last_msg = msg_data;
                n_msg_hs++;
                grant_log.push_back(0);
            end
            if (req_valid && req_ready) begin
                e_new.req  = req_data;
                e_new.hit  = 1'b0;
                e_new.tout = 1'b0;
                e_new.msg  = '0;
                if (ref_list.size() != 0) begin
                    if (list_silent) e_new.tout = 1'b1;
                    else begin
                        for (int i = 0; i < ref_list.size(); i++) begin
                            if (ref_list[i][111:88] == req_data[23:0]) begin
                                e_new.hit = 1'b1;
                                e_new.msg = ref_list[i];
                                ref_list.delete(i);
                                break;
                            end
                        end
                    end
                end
                exp_q.push_back(e_new);
                last_req = 32'(req_data);
                n_req_hs++;
                grant_log.push_back(1);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rsp: got request %h expected no response", rsp_request);
                end else begin
                    e_got = exp_q.pop_front();
                    check("rsp_hit", PW'(rsp_hit), PW'(e_got.hit));
                    check("rsp_timeout", PW'(rsp_timeout), PW'(e_got.tout));
                    check("rsp_message", rsp_message, e_got.msg);
                    check("rsp_request", PW'(rsp_request), PW'(e_got.req));
                    check("occupancy", PW'(occupancy), PW'(ref_list.size()));
                end
            end
        end
    end

    // ---------------- rsp_ready driver ----------------
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_msg(input logic [PW-1:0] d);
        int unsigned n = 0;
        bit ok = 0;
        @(posedge clk); #1;
        msg_valid = 1'b1;
        msg_data = d;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = msg_ready;
            n++;
        end
        // Giving up is only legitimate while the list is full.
        if (!ok && ref_list.size() < DEP) begin
            checks++;
            $display("FAIL msg_accept_timeout: got no msg_ready expected accept, ref size %0d", ref_list.size());
        end
        @(posedge clk); #1;
        msg_valid = 1'b0;
    endtask

    task automatic send_req(input logic [RW-1:0] d);
        int unsigned n = 0;
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data = d;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = req_ready;
            n++;
        end
        if (!ok) begin
            checks++;
            $display("FAIL req_accept_timeout: got no req_ready expected accept of %h", d);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            n++;
            if (n > 1000) begin
                checks++;
                $display("FAIL drain_timeout: got pending=%0d busy=%0b expected idle", exp_q.size(), busy);
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned   f0, i0, h0, r0, n, rise;
        logic [PW-1:0] m, snap_msg;
        logic [RW-1:0] snap_req;
        logic          snap_tout;

        msg_valid = 0; req_valid = 0; msg_data = '0; req_data = '0; ll_q_full = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_busy", PW'(busy), '0);
        check("reset_rsp_valid", PW'(rsp_valid), '0);
        check("reset_occupancy", PW'(occupancy), '0);
        check("reset_strobes", PW'({ll_insert, ll_find, msg_ready, req_ready}), '0);

        // Find on an empty list answers a miss without touching the list.
        ready_mode = 2;
        f0 = n_find;
        send_req(32'h00010203);
        drain();
        check("empty_no_find", PW'(n_find - f0), '0);

        // Insert then matching find.
        i0 = n_insert;
        m = make_msg(24'h010203);
        send_msg(m);
        drain();
        check("insert_pulse_cycles", PW'(n_insert - i0), PW'(1));
        check("occ_after_insert", PW'(occupancy), PW'(1));
        send_req(32'h00010203);
        drain();
        check("occ_after_hit", PW'(occupancy), '0);

        // Both streams held: grants alternate starting with msg after reset.
        do_reset();
        grant_log.delete();
        @(posedge clk); #1;
        msg_valid = 1'b1; msg_data = make_msg(24'h0A0B0C);
        req_valid = 1'b1; req_data = 32'h000A0B0C;
        n = 0;
        while (grant_log.size() < 4 && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        msg_valid = 1'b0; req_valid = 1'b0;
        if (grant_log.size() < 4) begin
            checks++;
            $display("FAIL rr_grants: got %0d grants expected 4", grant_log.size());
        end else begin
            for (int i = 0; i < 4; i++) check("rr_order", PW'(grant_log[i]), PW'(i % 2));
        end
        drain();

        // List full: msg stays blocked, req still served.
        h0 = n_msg_hs; r0 = n_req_hs;
        @(posedge clk); #1;
        ll_q_full = 1'b1; msg_valid = 1'b1; msg_data = make_msg(24'h000055);
        send_req(32'h00000077);
        drain();
        repeat (3) @(negedge clk);
        check("full_msg_blocked", PW'(n_msg_hs - h0), '0);
        check("full_req_served", PW'(n_req_hs - r0), PW'(1));
        @(posedge clk); #1;
        msg_valid = 1'b0; ll_q_full = 1'b0;

        // Silent list: timeout exactly TMO cycles after WAIT entry, response held.
        send_msg(make_msg(24'h000042));
        drain();
        list_silent = 1; ready_mode = 1;
        send_req(32'h00000042);
        n = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid || n > TMO + 50) break;
            n++;
        end
        rise = cyc;
        check("timeout_latency", PW'(rise - find_cyc), PW'(TMO + 1));
        snap_tout = rsp_timeout; snap_msg = rsp_message; snap_req = rsp_request;
        check("timeout_flag", PW'(snap_tout), PW'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", PW'(rsp_valid), PW'(1));
            check("hold_timeout", PW'(rsp_timeout), PW'(snap_tout));
            check("hold_message", rsp_message, snap_msg);
            check("hold_request", PW'(rsp_request), PW'(snap_req));
        end
        ready_mode = 2;
        drain();

        // Reset while waiting on the list.
        send_req(32'h00000042);
        n = 0;
        while (!busy || n < 4) begin @(negedge clk); n++; if (n > 50) break; end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_busy", PW'(busy), '0);
        check("rst_rsp_valid", PW'({rsp_valid, rsp_hit, rsp_timeout}), '0);
        check("rst_strobes", PW'({ll_insert, ll_find, msg_ready, req_ready}), '0);
        check("rst_occupancy", PW'(occupancy), '0);
        check("rst_rsp_message", rsp_message, '0);
        check("rst_ll_request", PW'(ll_request), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        list_silent = 0;
        f0 = n_find;
        send_req(32'h00000042);
        drain();
        check("post_rst_no_find", PW'(n_find - f0), '0);

        // Fill to DEPTH: occupancy saturates and msg is refused.
        for (int i = 0; i < DEP; i++) send_msg(make_msg(24'hFFFFFF));
        drain();
        check("occ_full", PW'(occupancy), PW'(DEP));
        h0 = n_msg_hs;
        @(posedge clk); #1;
        msg_valid = 1'b1; msg_data = make_msg(24'h000001);
        repeat (20) @(negedge clk);
        check("depth_msg_blocked", PW'(n_msg_hs - h0), '0);
        @(posedge clk); #1;
        msg_valid = 1'b0;
        for (int i = 0; i <= DEP; i++) send_req(32'h00FFFFFF);
        drain();
        check("occ_drained", PW'(occupancy), '0);

        // Randomized traffic on both streams.
        ready_mode = 0;
        fork
            for (int i = 0; i < 60; i++) begin
                send_msg(make_msg(24'($urandom_range(0, 5))));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            for (int i = 0; i < 60; i++) begin
                send_req(32'($urandom_range(0, 5)));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        join
        ready_mode = 2;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/umq_scheduler.md
UMQ_SCHEDULER -- requirements
Module: umq_scheduler

Interface
REQ-001 SHALL have parameter PKT_WIDTH, default 128, network message width.
REQ-002 SHALL have parameter REQ_WIDTH, default 32, receive request width ({8'b0, comm[23:16], src[15:8], tag[7:0]}).
REQ-003 SHALL have parameter DEPTH, default 1023, usable list entries.
REQ-004 SHALL have parameter TIMEOUT, default 1100, max WAIT cycles.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, async active-high reset.
REQ-006 SHALL have msg_valid in 1, msg_data in PKT_WIDTH, msg_ready out 1: network insert stream.
REQ-007 SHALL have req_valid in 1, req_data in REQ_WIDTH, req_ready out 1: receive-post find stream.
REQ-008 SHALL have ll_insert out 1, ll_find out 1, ll_message out PKT_WIDTH, ll_request out 32: list command side.
REQ-009 SHALL have ll_found in 1, ll_not_found in 1, ll_q_full in 1, ll_unexpected_message in PKT_WIDTH: list status side.
REQ-010 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_hit out 1, rsp_timeout out 1, rsp_message out PKT_WIDTH, rsp_request out REQ_WIDTH: find response.
REQ-011 SHALL have occupancy out 10, busy out 1.

Function
REQ-012 SHALL use FSM states IDLE, INS, INS_SETTLE, FIND, WAIT, RESP; encoding from package.
REQ-013 SHALL assert msg_ready only in IDLE when msg is granted and not full (full = ll_q_full or occupancy == DEPTH).
REQ-014 SHALL assert req_ready only in IDLE when req is granted; a transfer is valid & ready in the same cycle.
REQ-015 SHALL arbitrate round-robin when both are eligible: grant the stream not granted last; after reset msg wins first.
REQ-016 SHALL grant a lone eligible stream regardless of the round-robin pointer; when full, msg is ineligible.
REQ-017 SHALL register the message on accept, then in INS drive ll_insert high for exactly 1 cycle with ll_message stable.
REQ-018 SHALL increment occupancy in INS, then spend 1 cycle in INS_SETTLE, then return to IDLE (insert-to-next-accept = 3 cycles).
REQ-019 SHALL, on req accept with occupancy == 0, skip the list and go directly to RESP with hit=0, timeout=0, message=0.
REQ-020 SHALL otherwise drive ll_find high for 1 cycle in FIND, hold ll_request stable through WAIT, and clear the timeout counter.
REQ-021 SHALL, in WAIT, on ll_found latch hit=1 and ll_unexpected_message, decrement occupancy, and go to RESP.
REQ-022 SHALL, in WAIT, on ll_not_found latch hit=0 and message=0, and go to RESP.
REQ-023 SHALL treat ll_found and ll_not_found high together as found.
REQ-024 SHALL, when WAIT reaches TIMEOUT cycles without a result, go to RESP with hit=0 and timeout=1; late status pulses are ignored outside WAIT.
REQ-025 SHALL, in RESP, hold rsp_valid and all rsp_* stable until rsp_ready, then go to IDLE the next cycle.
REQ-026 SHALL echo the accepted req_data on rsp_request.
REQ-027 SHALL never assert ll_insert and ll_find in the same cycle; only one list operation is outstanding.
REQ-028 SHALL saturate occupancy at DEPTH and 0 (no wrap).
REQ-029 SHALL drive busy = (state != IDLE).

Reset
REQ-030 SHALL, on rst assertion at any time, force state IDLE, occupancy 0, round-robin pointer to msg, timeout counter 0, and all outputs 0 without waiting for clk.
REQ-031 SHALL discard any in-flight response on reset mid-operation; the list is reset by the same rst.

Structure
REQ-032 SHALL put the state encoding, PKT_WIDTH/REQ_WIDTH defaults, DEPTH, TIMEOUT and the counter width in shared package umq_pkg.
REQ-033 SHALL place the 2-way round-robin arbiter in sub-module umq_rr_arb2 (req[1:0], update, grant[1:0], async reset).

Verification
REQ-034 SHALL test: after reset, req_valid with req_data=0x00010203 -> rsp_valid, hit=0, timeout=0, no ll_find pulse.
REQ-035 SHALL test: insert msg with [111:88]=0x010203, then find 0x00010203 -> ll_insert 1 cycle, then rsp hit=1, rsp_message=msg, occupancy 1->0.
REQ-036 SHALL test: msg_valid and req_valid held together for 4 grants -> grants alternate msg, req, msg, req.
REQ-037 SHALL test: ll_q_full=1 with both valid -> msg_ready stays 0 and req is served.
REQ-038 SHALL test: list model never answers -> rsp_timeout=1 exactly TIMEOUT cycles after WAIT entry; rsp_ready held low 5 cycles -> rsp_* stable.
REQ-039 SHALL test: rst pulsed during WAIT -> all outputs 0 immediately, occupancy 0, next req served normally.
